// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures line/frame timing from an active-low
// hsync/vsync pair, recovers position counters and declares lock once stable.
module vga_sync_monitor #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_n,
  input  logic             vsync_n,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic [CNT_W-1:0] htotal,
  output logic [CNT_W-1:0] hsync_len,
  output logic [CNT_W-1:0] vtotal,
  output logic [CNT_W-1:0] vsync_len,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [3:0]       GoodMax = 4'hF;
  localparam logic [3:0]       LockCnt = 4'(LOCK_FRAMES);

  logic             h_s_q, h_sd_q, v_s_q, v_sd_q;
  logic [CNT_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [CNT_W-1:0] htotal_q, htotal_d, hsync_len_q, hsync_len_d;
  logic [CNT_W-1:0] vtotal_q, vtotal_d, vsync_len_q, vsync_len_d;
  logic             line_start_q, frame_start_q;
  logic             locked_q, locked_d, err_q, err_d;
  logic             h_armed_q, h_armed_d, h_valid_q, h_valid_d;
  logic             v_armed_q, v_armed_d, v_valid_q, v_valid_d;
  logic             line_err_q, line_err_d;
  logic [3:0]       good_cnt_q, good_cnt_d;

  logic             h_rise, h_fall, v_rise, v_fall;
  logic [CNT_W-1:0] hpos_inc, vpos_base;
  logic             line_mis, good_frame, sync_loss, drop;

  assign h_rise = h_s_q & ~h_sd_q;
  assign h_fall = ~h_s_q & h_sd_q;
  assign v_rise = v_s_q & ~v_sd_q;
  assign v_fall = ~v_s_q & v_sd_q;

  // Next-state: measurements, position counters and lock qualification
  always_comb begin
    hpos_inc    = (hpos_q == CntMax) ? hpos_q : hpos_q + 1'b1;
    // A coincident hsync edge counts as the first line of the new frame
    vpos_base   = v_rise ? '0 : vpos_q;
    hpos_d      = h_rise ? '0 : hpos_inc;
    vpos_d      = (h_rise && vpos_base != CntMax) ? vpos_base + 1'b1 : vpos_base;
    htotal_d    = htotal_q;
    hsync_len_d = hsync_len_q;
    vtotal_d    = vtotal_q;
    vsync_len_d = vsync_len_q;
    h_armed_d   = h_armed_q;
    h_valid_d   = h_valid_q;
    v_armed_d   = v_armed_q;
    v_valid_d   = v_valid_q;

    if (h_rise) begin
      h_armed_d = 1'b1;
      if (h_armed_q) begin
        htotal_d  = hpos_inc;
        h_valid_d = 1'b1;
      end
    end
    if (h_fall && h_armed_q) hsync_len_d = hpos_inc;

    if (v_rise) begin
      v_armed_d = 1'b1;
      if (v_armed_q) begin
        vtotal_d  = vpos_q;
        v_valid_d = 1'b1;
      end
    end
    if (v_fall && v_armed_q) vsync_len_d = vpos_q;

    line_mis   = h_rise & h_valid_q & (hpos_inc != htotal_q);
    good_frame = v_valid_q & (vpos_q == vtotal_q) & ~line_err_q & h_valid_q;
    sync_loss  = (hpos_q == CntMax) | (vpos_q == CntMax);
    drop       = line_mis | (v_rise & ~good_frame) | sync_loss;

    line_err_d = v_rise ? 1'b0 : (line_err_q | line_mis);

    good_cnt_d = good_cnt_q;
    if (drop) begin
      good_cnt_d = '0;
    end else if (v_rise && good_cnt_q != GoodMax) begin
      good_cnt_d = good_cnt_q + 1'b1;
    end

    locked_d = ~drop & (good_cnt_q >= LockCnt);
    err_d    = locked_q & ~locked_d;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      h_s_q         <= 1'b0;
      h_sd_q        <= 1'b0;
      v_s_q         <= 1'b0;
      v_sd_q        <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      htotal_q      <= '0;
      hsync_len_q   <= '0;
      vtotal_q      <= '0;
      vsync_len_q   <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      h_armed_q     <= 1'b0;
      h_valid_q     <= 1'b0;
      v_armed_q     <= 1'b0;
      v_valid_q     <= 1'b0;
      line_err_q    <= 1'b0;
      good_cnt_q    <= '0;
    end else begin
      h_s_q         <= ~hsync_n;
      h_sd_q        <= h_s_q;
      v_s_q         <= ~vsync_n;
      v_sd_q        <= v_s_q;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      htotal_q      <= htotal_d;
      hsync_len_q   <= hsync_len_d;
      vtotal_q      <= vtotal_d;
      vsync_len_q   <= vsync_len_d;
      line_start_q  <= h_rise;
      frame_start_q <= v_rise;
      locked_q      <= locked_d;
      err_q         <= err_d;
      h_armed_q     <= h_armed_d;
      h_valid_q     <= h_valid_d;
      v_armed_q     <= v_armed_d;
      v_valid_q     <= v_valid_d;
      line_err_q    <= line_err_d;
      good_cnt_q    <= good_cnt_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign htotal      = htotal_q;
  assign hsync_len   = hsync_len_q;
  assign vtotal      = vtotal_q;
  assign vsync_len   = vsync_len_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule
